// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO management responder: decodes oversampled mdc/mdio frames
// against a 32 x 16 PHY register file and drives read data back on mdio_o.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter int unsigned PRE_MIN  = 32,
  parameter logic [15:0] PHY_ID1  = 16'h0022,
  parameter logic [15:0] PHY_ID2  = 16'h1622,
  parameter logic [31:0] RO_MASK  = 32'h0000_000E
) (
  input  logic        clk_int,
  input  logic        rst_int_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        loc_we,
  input  logic [4:0]  loc_addr,
  input  logic [15:0] loc_wdata,
  output logic [15:0] loc_rdata,
  output logic        frame_done,
  output logic        frame_err
);

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;
  localparam int unsigned CW   = 6;
  localparam int unsigned BW   = 5;
  localparam int unsigned SW   = 15;
  localparam logic [CW-1:0] PRE_SAT = CW'(63);
  localparam logic [CW-1:0] PRE_THR = CW'(PRE_MIN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ST    = 3'd1,
    S_OP    = 3'd2,
    S_PHYAD = 3'd3,
    S_REGAD = 3'd4,
    S_TA    = 3'd5,
    S_DATA  = 3'd6
  } state_t;

  state_t state, state_nxt;

  logic mdc_m, mdc_s, mdc_h, mdio_m, mdio_s;
  logic rise_c, fall_c;

  logic [CW-1:0] pre_cnt, pre_cnt_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic          is_read, is_read_nxt;
  logic          match, match_nxt;
  logic [SW-1:0] sh, sh_nxt;
  logic [AW-1:0] regad, regad_nxt;
  logic [DW-1:0] snap, snap_nxt;
  logic          mdio_o_nxt, mdio_oe_nxt;
  logic          frame_done_nxt, frame_err_nxt;
  logic          mdio_we_c;
  logic [DW-1:0] mdio_wdata_c;
  logic [AW-1:0] field_c;

  logic [DW-1:0] rf [NREG];

  // Two-flop synchronisers plus an mdc history flop for edge detection
  always_ff @(posedge clk_int or negedge rst_int_n) begin
    if (!rst_int_n) begin
      mdc_m  <= 1'b0;
      mdc_s  <= 1'b0;
      mdc_h  <= 1'b0;
      mdio_m <= 1'b0;
      mdio_s <= 1'b0;
    end else begin
      mdc_m  <= mdc;
      mdc_s  <= mdc_m;
      mdc_h  <= mdc_s;
      mdio_m <= mdio_i;
      mdio_s <= mdio_m;
    end
  end

  assign rise_c       = mdc_s & ~mdc_h;
  assign fall_c       = ~mdc_s & mdc_h;
  assign field_c      = {sh[3:0], mdio_s};
  assign mdio_wdata_c = {sh, mdio_s};

  // State register
  always_ff @(posedge clk_int or negedge rst_int_n) begin
    if (!rst_int_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic, advanced only on mdc rising edges
  always_comb begin
    state_nxt = state;
    if (rise_c) begin
      case (state)
        S_IDLE:  if (!mdio_s && (pre_cnt >= PRE_THR)) state_nxt = S_ST;
        S_ST:    state_nxt = mdio_s ? S_OP : S_IDLE;
        S_OP:    if (bit_cnt == BW'(1)) state_nxt = (sh[0] != mdio_s) ? S_PHYAD : S_IDLE;
        S_PHYAD: if (bit_cnt == BW'(4)) state_nxt = S_REGAD;
        S_REGAD: if (bit_cnt == BW'(4)) state_nxt = S_TA;
        S_TA: begin
          if (!is_read && (bit_cnt == '0) && !mdio_s)
            state_nxt = S_IDLE;
          else if (bit_cnt == BW'(1))
            state_nxt = (!is_read && mdio_s) ? S_IDLE : S_DATA;
        end
        S_DATA:  if (bit_cnt == BW'(15)) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath and output next values: decode on rise, drive mdio on fall
  always_comb begin
    pre_cnt_nxt    = pre_cnt;
    bit_cnt_nxt    = bit_cnt;
    is_read_nxt    = is_read;
    match_nxt      = match;
    sh_nxt         = sh;
    regad_nxt      = regad;
    snap_nxt       = snap;
    mdio_o_nxt     = mdio_o;
    mdio_oe_nxt    = mdio_oe;
    frame_done_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
    mdio_we_c      = 1'b0;

    if (rise_c) begin
      sh_nxt      = {sh[SW-2:0], mdio_s};
      bit_cnt_nxt = ((state_nxt != state) || (state == S_IDLE)) ? '0 : bit_cnt + BW'(1);
      case (state)
        S_IDLE: begin
          if (mdio_s) begin
            if (pre_cnt != PRE_SAT) pre_cnt_nxt = pre_cnt + CW'(1);
          end else begin
            pre_cnt_nxt = '0;
          end
        end
        S_ST: frame_err_nxt = !mdio_s;
        S_OP: begin
          if (bit_cnt == BW'(1)) begin
            is_read_nxt   = sh[0];
            frame_err_nxt = (sh[0] == mdio_s);
          end
        end
        S_PHYAD: if (bit_cnt == BW'(4)) match_nxt = (field_c == PHY_ADDR);
        S_REGAD: begin
          if (bit_cnt == BW'(4)) begin
            regad_nxt = field_c;
            snap_nxt  = rf[field_c];
          end
        end
        // Write turnaround must be 1,0; a foreign-address frame stays silent
        S_TA: begin
          if (!is_read && (((bit_cnt == '0) && !mdio_s) || ((bit_cnt == BW'(1)) && mdio_s)))
            frame_err_nxt = match;
        end
        S_DATA: begin
          snap_nxt = {snap[DW-2:0], 1'b0};
          if (bit_cnt == BW'(15)) begin
            frame_done_nxt = match;
            pre_cnt_nxt    = '0;
            mdio_we_c      = match && !is_read && !RO_MASK[regad];
          end
        end
        default: ;
      endcase
    end

    if (fall_c) begin
      case (state)
        S_TA: begin
          if (is_read && match) begin
            mdio_oe_nxt = 1'b1;
            mdio_o_nxt  = 1'b0;
          end
        end
        S_DATA: if (is_read && match) mdio_o_nxt = snap[DW-1];
        S_IDLE: begin
          mdio_oe_nxt = 1'b0;
          mdio_o_nxt  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_int or negedge rst_int_n) begin
    if (!rst_int_n) begin
      pre_cnt    <= '0;
      bit_cnt    <= '0;
      is_read    <= 1'b0;
      match      <= 1'b0;
      sh         <= '0;
      regad      <= '0;
      snap       <= '0;
      mdio_o     <= 1'b0;
      mdio_oe    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      pre_cnt    <= pre_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      is_read    <= is_read_nxt;
      match      <= match_nxt;
      sh         <= sh_nxt;
      regad      <= regad_nxt;
      snap       <= snap_nxt;
      mdio_o     <= mdio_o_nxt;
      mdio_oe    <= mdio_oe_nxt;
      frame_done <= frame_done_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

  // Register file; the local port is applied last so it wins a same-cycle collision
  always_ff @(posedge clk_int or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      rf[2] <= PHY_ID1;
      rf[3] <= PHY_ID2;
    end else begin
      if (mdio_we_c) rf[regad] <= mdio_wdata_c;
      if (loc_we)    rf[loc_addr] <= loc_wdata;
    end
  end

  assign loc_rdata = rf[loc_addr];

endmodule
